// File: rtl/switch_debounce_pkg.sv
// Shared definitions for input-conditioning blocks: debounce FSM state
// encodings and the default settle time.
package switch_debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } deb_state_e;

  // 10 ms at a 100 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage : switch_debounce_pkg

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchroniser, settle counter and a two-state debounce
// FSM producing a registered level plus registered rise/fall strobes.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             take;

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    take    = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (sync2_q != level_q) begin
          // A one-cycle settle time accepts on the very first disagreement
          if (CNT_LAST == '0) begin
            take = 1'b1;
          end else begin
            state_d = ST_SETTLING;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_SETTLING: begin
        if (sync2_q == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          take = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (take) begin
      level_d = sync2_q;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
      cnt_d   = '0;
      state_d = ST_STABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  // Lets the parent register a combined strobe in step with rise/fall
  assign accept_next = rise_d | fall_d;

endmodule : debounce_bit

// File: rtl/switch_debounce.sv
// Debounces WIDTH independent slide switches and provides a combined,
// registered change strobe for the downstream blink-rate selector.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] accept_next;
  logic             changed_q, changed_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .sw_raw     (sw_raw[gi]),
      .level      (switch[gi]),
      .rise       (sw_rise[gi]),
      .fall       (sw_fall[gi]),
      .accept_next(accept_next[gi])
    );
  end

  always_comb begin
    changed_d = |accept_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign sw_changed = changed_q;

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: directed scenarios plus random bouncing
// input, checked against a run-length reference model.
module tb_switch_debounce;

  localparam int W = 2;
  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] switch;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // {switch, sw_rise, sw_fall, sw_changed} expected after each edge
  logic [6:0] exp_q[$];

  // Model: raw passes two sample stages, then a bit takes a new level once
  // N consecutive post-synchroniser samples disagree with its current level.
  logic [W-1:0] m_s1;
  logic [W-1:0] m_s2;
  logic [W-1:0] m_level;
  int           m_mism[W];

  switch_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .switch    (switch),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic [W-1:0] raw);
    logic [W-1:0] rise_e;
    logic [W-1:0] fall_e;
    logic         seen;
    sw_raw = raw;
    reset  = rst;
    rise_e = '0;
    fall_e = '0;
    for (int b = 0; b < W; b++) begin
      if (rst) begin
        m_s1[b]    = 1'b0;
        m_s2[b]    = 1'b0;
        m_level[b] = 1'b0;
        m_mism[b]  = 0;
      end else begin
        seen    = m_s2[b];
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
        if (seen != m_level[b]) m_mism[b] = m_mism[b] + 1;
        else m_mism[b] = 0;
        if (m_mism[b] >= N) begin
          m_level[b] = seen;
          if (seen) rise_e[b] = 1'b1;
          else fall_e[b] = 1'b1;
          m_mism[b] = 0;
        end
      end
    end
    exp_q.push_back({m_level, rise_e, fall_e, |(rise_e | fall_e)});
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL outputs cycle %0d: {switch,rise,fall,changed} got %b expected %b",
               cycle, got, want);
    end
  endtask

  task automatic holdFor(input logic [W-1:0] raw, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, raw);
  endtask

  // Monitor: the DUT presents a registered result every cycle
  initial begin
    logic [6:0] want;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checkOutput({switch, sw_rise, sw_fall, sw_changed}, want);
      end
    end
  end

  initial begin
    logic [W-1:0] cur;
    m_s1    = '0;
    m_s2    = '0;
    m_level = '0;
    for (int b = 0; b < W; b++) m_mism[b] = 0;

    // Reset with switches high, then debounce from release
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b11);
    holdFor(2'b11, 10);
    // Simultaneous fall
    holdFor(2'b00, 10);
    // Clean edge on bit 0
    holdFor(2'b01, 10);
    // Bounce on bit 1
    holdFor(2'b11, 2);
    holdFor(2'b01, 2);
    holdFor(2'b11, 2);
    holdFor(2'b01, 2);
    holdFor(2'b11, 10);
    // Short glitch on bit 0
    holdFor(2'b10, 3);
    holdFor(2'b11, 10);
    // Simultaneous rise
    holdFor(2'b00, 10);
    holdFor(2'b11, 10);
    holdFor(2'b00, 10);
    // Reset mid-settle
    holdFor(2'b01, 2);
    applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b1, 2'b01);
    holdFor(2'b01, 10);

    // Random bouncing switches with occasional resets
    cur = 2'b01;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      applyStimulus($urandom_range(0, 149) == 0, cur);
    end
    holdFor(cur, 10);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected results left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_switch_debounce
